// File: rtl/sound_pkg.sv
// sound_pkg: shared types, default parameters and width helper for the
// multi-channel sound event detector.
package sound_pkg;

   // Debounce state of one channel
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      QUAL_ON  = 2'd1,
      ACTIVE   = 2'd2,
      QUAL_OFF = 2'd3
   } state_t;

   localparam int DEF_N_CH         = 2;
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_DEBOUNCE_CYC = 16;
   localparam int DEF_CNT_W        = 8;
   localparam int DEF_WINDOW_CYC   = 1000;

   // Bits needed to hold every value 0..max_val (at least 1 bit)
   function automatic int cnt_width(input int max_val);
      int w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) <= 64'(max_val)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/sound_channel.sv
// sound_channel: one sensor channel -- input synchroniser, debounce FSM,
// registered level/pulse outputs and a saturating event counter.
// Optional macro DOUBLE_EVENT_EN adds a per-channel double-event window timer;
// without it o_double is tied low.
module sound_channel
   import sound_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int WINDOW_CYC   = DEF_WINDOW_CYC
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sound,
   input  logic             i_clear_cnt,
   output logic             o_level,
   output logic             o_pulse,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_double
);

   localparam int DCNT_W = cnt_width(DEBOUNCE_CYC);
   // Count value on the sample that completes qualification
   localparam logic [DCNT_W-1:0] DCNT_FULL = DCNT_W'(DEBOUNCE_CYC);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1'b1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DCNT_W-1:0]      r_dcnt;
   logic [DCNT_W-1:0]      w_dcnt_nxt;
   logic [DCNT_W-1:0]      w_dcnt_inc;
   logic                   w_pulse_nxt;
   logic                   w_level_nxt;
   logic                   r_level;
   logic                   r_pulse;
   logic [CNT_W-1:0]       r_cnt;

   assign w_s        = r_sync[SYNC_STAGES-1];
   // Only evaluated in the qualifying states, where r_dcnt < DEBOUNCE_CYC
   assign w_dcnt_inc = r_dcnt + DCNT_ONE;

   // Multi-flop synchroniser for the asynchronous sensor pin
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sound};
      end
   end

   // Debounce state and qualification counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_dcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dcnt  <= w_dcnt_nxt;
      end
   end

   // Next-state logic: a level change needs DEBOUNCE_CYC equal samples in a row
   always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      case (r_state)
         IDLE: begin
            if (w_s) begin
               w_dcnt_nxt = DCNT_ONE;
               if (DEBOUNCE_CYC == 1) begin
                  w_state_nxt = ACTIVE;
               end else begin
                  w_state_nxt = QUAL_ON;
               end
            end else begin
               w_dcnt_nxt = '0;
            end
         end
         QUAL_ON: begin
            if (!w_s) begin
               w_state_nxt = IDLE;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt >= DCNT_LAST) begin
               w_state_nxt = ACTIVE;
               w_dcnt_nxt  = DCNT_FULL;
            end else begin
               w_dcnt_nxt = w_dcnt_inc;
            end
         end
         ACTIVE: begin
            if (!w_s) begin
               w_dcnt_nxt = DCNT_ONE;
               if (DEBOUNCE_CYC == 1) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = QUAL_OFF;
               end
            end else begin
               w_dcnt_nxt = '0;
            end
         end
         QUAL_OFF: begin
            if (w_s) begin
               // Dip too short: back to ACTIVE, no new event
               w_state_nxt = ACTIVE;
               w_dcnt_nxt  = '0;
            end else if (r_dcnt >= DCNT_LAST) begin
               w_state_nxt = IDLE;
               w_dcnt_nxt  = DCNT_FULL;
            end else begin
               w_dcnt_nxt = w_dcnt_inc;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_dcnt_nxt  = '0;
         end
      endcase
   end

   // Output decode from the next state so level and pulse are registered
   always_comb begin
      w_pulse_nxt = 1'b0;
      w_level_nxt = 1'b0;
      if ((w_state_nxt == ACTIVE) && ((r_state == IDLE) || (r_state == QUAL_ON))) begin
         w_pulse_nxt = 1'b1;
      end else begin
         w_pulse_nxt = 1'b0;
      end
      if ((w_state_nxt == ACTIVE) || (w_state_nxt == QUAL_OFF)) begin
         w_level_nxt = 1'b1;
      end else begin
         w_level_nxt = 1'b0;
      end
   end

   // Registered level and rising-event pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_level <= w_level_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   // Saturating event counter; clear wins but still counts a coincident pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear_cnt) begin
         r_cnt <= r_pulse ? CNT_ONE : '0;
      end else if (r_pulse && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;
   assign o_cnt   = r_cnt;

`ifdef DOUBLE_EVENT_EN
   localparam int                TMR_W    = cnt_width(WINDOW_CYC);
   localparam logic [TMR_W-1:0]  WIN_FULL = TMR_W'(WINDOW_CYC);
   localparam logic [TMR_W-1:0]  WIN_LAST = TMR_W'(WINDOW_CYC - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1'b1);

   logic             r_win_open;
   logic [TMR_W-1:0] r_timer;
   logic             r_double;

   // Window timer: decided on the edge that raises o_pulse, so the timer reads
   // 0 during the opening pulse and o_double lines up with the second pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_win_open <= 1'b0;
         r_timer    <= '0;
         r_double   <= 1'b0;
      end else begin
         r_double <= 1'b0;
         if (w_pulse_nxt) begin
            // Timer will read r_timer+1 in the pulse cycle
            if (r_win_open && (r_timer < WIN_LAST)) begin
               r_double   <= 1'b1;
               r_win_open <= 1'b0;
               r_timer    <= '0;
            end else begin
               r_win_open <= 1'b1;
               r_timer    <= '0;
            end
         end else if (r_win_open) begin
            if (r_timer >= WIN_FULL) begin
               r_win_open <= 1'b0;
               r_timer    <= '0;
            end else begin
               r_timer <= r_timer + TMR_ONE;
            end
         end else begin
            r_timer <= '0;
         end
      end
   end

   assign o_double = r_double;
`else
   // Window length is irrelevant without the feature; output held low
   localparam logic DBL_TIE = (WINDOW_CYC > 0) ? 1'b0 : 1'b0;
   assign o_double = DBL_TIE;
`endif

endmodule

// File: rtl/sound_event_detector.sv
// sound_event_detector: N_CH independent debounced sound-sensor channels with
// level, rising-event pulse and saturating counters, plus a registered
// any-channel flag. Optional macro DOUBLE_EVENT_EN enables per-channel
// double-event detection on o_double_pulse (tied low otherwise).
module sound_event_detector
   import sound_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int WINDOW_CYC   = DEF_WINDOW_CYC
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [N_CH-1:0]       i_sound_in,
   input  logic                  i_clear_cnt,
   output logic [N_CH-1:0]       o_sound_level,
   output logic [N_CH-1:0]       o_sound_pulse,
   output logic [N_CH*CNT_W-1:0] o_event_cnt,
   output logic                  o_any_detected,
   output logic [N_CH-1:0]       o_double_pulse
);

   logic [N_CH-1:0] w_level;
   logic            r_any;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      sound_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .CNT_W        (CNT_W),
         .WINDOW_CYC   (WINDOW_CYC)
      ) u_channel (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_sound     (i_sound_in[g]),
         .i_clear_cnt (i_clear_cnt),
         .o_level     (w_level[g]),
         .o_pulse     (o_sound_pulse[g]),
         .o_cnt       (o_event_cnt[g*CNT_W +: CNT_W]),
         .o_double    (o_double_pulse[g])
      );
   end

   // Registered OR of all channel levels (one cycle behind the levels)
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_any <= 1'b0;
      end else begin
         r_any <= |w_level;
      end
   end

   assign o_sound_level  = w_level;
   assign o_any_detected = r_any;

endmodule

// File: tb/tb_sound_event_detector.sv
// Scoreboard bench for sound_event_detector (DEBOUNCE_CYC=4, SYNC_STAGES=2,
// CNT_W=4, WINDOW_CYC=50, N_CH=2) plus a DEBOUNCE_CYC=1 single-channel instance.
`timescale 1ns/1ps
module tb_sound_event_detector;

   localparam int N_CH    = 2;
   localparam int SYNC    = 2;
   localparam int DEB     = 4;
   localparam int CNT_W   = 4;
   localparam int WIN     = 50;
   localparam int LAT     = SYNC + DEB - 1;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CH-1:0]       sound_in;
   logic                  clear_cnt;
   logic [N_CH-1:0]       o_sound_level;
   logic [N_CH-1:0]       o_sound_pulse;
   logic [N_CH*CNT_W-1:0] o_event_cnt;
   logic                  o_any_detected;
   logic [N_CH-1:0]       o_double_pulse;

   logic [0:0]       sound1;
   logic [0:0]       lvl1;
   logic [0:0]       pls1;
   logic [CNT_W-1:0] cnt1;
   logic             any1;
   logic [0:0]       dbl1;

   sound_event_detector #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .CNT_W(CNT_W), .WINDOW_CYC(WIN)
   ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_sound_in(sound_in), .i_clear_cnt(clear_cnt),
      .o_sound_level(o_sound_level), .o_sound_pulse(o_sound_pulse),
      .o_event_cnt(o_event_cnt), .o_any_detected(o_any_detected),
      .o_double_pulse(o_double_pulse)
   );

   sound_event_detector #(
      .N_CH(1), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(1), .CNT_W(CNT_W), .WINDOW_CYC(WIN)
   ) u_dut_d1 (
      .i_clk(clk), .i_rst(rst), .i_sound_in(sound1), .i_clear_cnt(clear_cnt),
      .o_sound_level(lvl1), .o_sound_pulse(pls1),
      .o_event_cnt(cnt1), .o_any_detected(any1),
      .o_double_pulse(dbl1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct packed {
      int   cyc;
      int   cnt;
      logic dbl;
   } exp_t;

   exp_t exp_q [N_CH][$];
   int   model_cnt [N_CH];
`ifdef DOUBLE_EVENT_EN
   int   win_open  [N_CH];
   int   win_start [N_CH];
`endif

   // Expected pulse for a clean rise sampled at rise_edge
   function automatic void push_event(input int ch, input int rise_edge, input bit clr);
      exp_t e;
      int   p;
      p     = rise_edge + LAT;
      e.cyc = p;
      if (clr) begin
         for (int c = 0; c < N_CH; c++) model_cnt[c] = 0;
         model_cnt[ch] = 1;
      end else if (model_cnt[ch] < CNT_MAX) begin
         model_cnt[ch] = model_cnt[ch] + 1;
      end
      e.cnt = model_cnt[ch];
      e.dbl = 1'b0;
`ifdef DOUBLE_EVENT_EN
      if ((win_open[ch] != 0) && ((p - win_start[ch]) < WIN)) begin
         e.dbl        = 1'b1;
         win_open[ch] = 0;
      end else begin
         win_open[ch]  = 1;
         win_start[ch] = p;
      end
`endif
      exp_q[ch].push_back(e);
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < N_CH; c++) begin
         model_cnt[c] = 0;
`ifdef DOUBLE_EVENT_EN
         win_open[c] = 0;
`endif
      end
   endfunction

   int pend_v   [N_CH];
   int pend_cnt [N_CH];

   // Monitor: pops the scoreboard on each pulse, checks count one cycle later
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < N_CH; c++) begin
            if (pend_v[c] != 0) begin
               check("event_cnt", o_event_cnt[c*CNT_W +: CNT_W], pend_cnt[c]);
               pend_v[c] <= 0;
            end
            if (o_sound_pulse[c]) begin
               if (exp_q[c].size() == 0) begin
                  check("unexpected_pulse", 1, 0);
               end else begin
                  check("pulse_cycle", cyc, exp_q[c][0].cyc);
                  check("double_pulse", o_double_pulse[c], exp_q[c][0].dbl);
                  pend_cnt[c] <= exp_q[c][0].cnt;
                  pend_v[c]   <= 1;
                  void'(exp_q[c].pop_front());
               end
            end else begin
               check("double_idle", o_double_pulse[c], 0);
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Clean event on one channel; clr raises clear_cnt in the pulse cycle
   task automatic event_ch(input int ch, input int hi, input int lo, input bit clr);
      int e;
      sound_in[ch] = 1'b1;
      e = cyc + 1;
      push_event(ch, e, clr);
      for (int k = 0; k < hi; k++) begin
         step(1);
         clear_cnt = (clr && (cyc == e + LAT)) ? 1'b1 : 1'b0;
      end
      clear_cnt    = 1'b0;
      sound_in[ch] = 1'b0;
      step(lo);
   endtask

   // Rise/fall latency and any_detected lag on an otherwise idle DUT
   task automatic check_rise(input int ch);
      int e;
      sound_in[ch] = 1'b1;
      e = cyc + 1;
      push_event(ch, e, 1'b0);
      step(LAT);
      check("level_before_rise", o_sound_level[ch], 0);
      step(1);
      check("level_rise", o_sound_level[ch], 1);
      check("any_lag", o_any_detected, 0);
      step(1);
      check("any_set", o_any_detected, 1);
      step(1);
      sound_in[ch] = 1'b0;
      step(LAT);
      check("level_before_fall", o_sound_level[ch], 1);
      step(1);
      check("level_fall", o_sound_level[ch], 0);
      step(4);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      for (int c = 0; c < N_CH; c++) begin
         pend_v[c]   = 0;
         pend_cnt[c] = 0;
      end
      model_reset();
      rst       = 1'b1;
      sound_in  = '0;
      sound1    = '0;
      clear_cnt = 1'b0;
      step(3);
      check("rst_level", o_sound_level, 0);
      check("rst_pulse", o_sound_pulse, 0);
      check("rst_cnt", o_event_cnt, 0);
      check("rst_any", o_any_detected, 0);
      check("rst_double", o_double_pulse, 0);
      check("rst_d1_level", lvl1, 0);
      rst = 1'b0;
      step(6);

      // 1: single clean event on ch0
      check_rise(0);
      check("t1_ch1_level", o_sound_level[1], 0);
      check("t1_ch0_cnt", o_event_cnt[CNT_W-1:0], 1);
      check("t1_ch1_cnt", o_event_cnt[2*CNT_W-1:CNT_W], 0);

      // 2: short high glitch, then short low dip while active
      sound_in[0] = 1'b1;
      step(3);
      sound_in[0] = 1'b0;
      step(10);
      check("t2_glitch_level", o_sound_level[0], 0);
      check("t2_glitch_cnt", o_event_cnt[CNT_W-1:0], model_cnt[0]);
      sound_in[0] = 1'b1;
      push_event(0, cyc + 1, 1'b0);
      step(8);
      sound_in[0] = 1'b0;
      step(3);
      sound_in[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step(1);
         check("t2_dip_level", o_sound_level[0], 1);
      end
      sound_in[0] = 1'b0;
      step(10);
      check("t2_dip_fall", o_sound_level[0], 0);
      check("t2_dip_cnt", o_event_cnt[CNT_W-1:0], 2);

      // 3: saturation on ch1, then clear coincident with a pulse
      for (int k = 0; k < 17; k++) event_ch(1, 6, 6, 1'b0);
      check("t3_saturated", o_event_cnt[2*CNT_W-1:CNT_W], CNT_MAX);
      event_ch(1, 8, 6, 1'b1);
      check("t3_clear_pulse", o_event_cnt[2*CNT_W-1:CNT_W], 1);
      check("t3_clear_other", o_event_cnt[CNT_W-1:0], 0);

      // 4: simultaneous rise, reset during QUAL_OFF, fresh event afterwards
      clear_cnt = 1'b1;
      step(1);
      clear_cnt = 1'b0;
      model_reset();
      step(1);
      check("t4_cleared", o_event_cnt, 0);
      step(60);
      sound_in = 2'b11;
      push_event(0, cyc + 1, 1'b0);
      push_event(1, cyc + 1, 1'b0);
      step(8);
      check("t4_both_level", o_sound_level, 2'b11);
      check("t4_both_cnt", o_event_cnt, {4'd1, 4'd1});
      sound_in = 2'b00;
      step(3);
      check("t4_qual_off_level", o_sound_level, 2'b11);
      rst = 1'b1;
      #1;
      check("t4_rst_level", o_sound_level, 0);
      check("t4_rst_cnt", o_event_cnt, 0);
      check("t4_rst_any", o_any_detected, 0);
      model_reset();
      step(3);
      rst = 1'b0;
      step(3);
      check("t4_post_rst_level", o_sound_level, 0);
      check_rise(0);

      // 5: DEBOUNCE_CYC=1 instance, latency SYNC and a pulse per clean rise
      sound1 = 1'b1;
      step(2);
      check("t5_level_before", lvl1, 0);
      step(1);
      check("t5_level_rise", lvl1, 1);
      check("t5_pulse", pls1, 1);
      step(1);
      check("t5_pulse_one_cycle", pls1, 0);
      for (int k = 0; k < 3; k++) begin
         sound1 = 1'b0;
         step(3);
         check("t5_level_low", lvl1, 0);
         sound1 = 1'b1;
         step(3);
         check("t5_toggle_level", lvl1, 1);
         check("t5_toggle_pulse", pls1, 1);
      end
      step(1);
      check("t5_count", cnt1, 4);
      sound1 = 1'b0;
      step(60);

      // 6: double-event window (expected doubles only when the feature is built)
      event_ch(0, 8, 22, 1'b0);
      event_ch(0, 8, 60, 1'b0);
      event_ch(0, 8, 42, 1'b0);
      event_ch(0, 8, 12, 1'b0);
      event_ch(0, 8, 60, 1'b0);
      event_ch(0, 8, 12, 1'b0);
      event_ch(0, 8, 12, 1'b0);
      event_ch(0, 8, 60, 1'b0);

      step(10);
      for (int c = 0; c < N_CH; c++) begin
         check("scoreboard_empty", exp_q[c].size(), 0);
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
